// File: rtl/fpadd_pkg.sv
// Shared register map, CTRL/STAT bit positions and launch-FSM state type for the fpadd front-end.
package fpadd_pkg;

  localparam logic [3:0] ADDR_OPA  = 4'h0;
  localparam logic [3:0] ADDR_OPB  = 4'h4;
  localparam logic [3:0] ADDR_CTRL = 4'h8;
  localparam logic [3:0] ADDR_RES  = 4'hC;

  localparam int START_BIT = 0;
  localparam int BUSY_BIT  = 1;
  localparam int DONE_BIT  = 2;
  localparam int OVR_BIT   = 3;
  localparam int TMO_BIT   = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {IDLE, BUSY} fpadd_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fpadd_launch_ctrl.sv
// Launch FSM for the adder core: snapshots operands, pulses fp_start, waits for done or timeout.
// Status updates leave as single-cycle set pulses; the sticky bits live in the register file.
module fpadd_launch_ctrl
  import fpadd_pkg::*;
#(
  parameter int FP_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_req_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        fp_done_i,
  output logic        busy_o,
  output logic        fp_start_o,
  output logic [31:0] fp_a_o,
  output logic [31:0] fp_b_o,
  output logic        done_set_o,
  output logic        ovr_set_o,
  output logic        tmo_set_o
);

  localparam int TW = $clog2(FP_TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(FP_TIMEOUT - 1);

  fpadd_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic [31:0]   fp_a_q, fp_a_d;
  logic [31:0]   fp_b_q, fp_b_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      start_q <= 1'b0;
      fp_a_q  <= '0;
      fp_b_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      start_q <= start_d;
      fp_a_q  <= fp_a_d;
      fp_b_q  <= fp_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    start_d    = 1'b0;
    fp_a_d     = fp_a_q;
    fp_b_d     = fp_b_q;
    done_set_o = 1'b0;
    ovr_set_o  = 1'b0;
    tmo_set_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req_i) begin
          state_d = BUSY;
          start_d = 1'b1;
          timer_d = '0;
          fp_a_d  = opa_i;
          fp_b_d  = opb_i;
        end
      end
      BUSY: begin
        if (start_req_i) ovr_set_o = 1'b1;
        // A result arriving on the last allowed cycle still counts as done.
        if (fp_done_i) begin
          done_set_o = 1'b1;
          state_d    = IDLE;
        end else if (timer_q == TMAX) begin
          tmo_set_o = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  assign busy_o     = (state_q == BUSY);
  assign fp_start_o = start_q;
  assign fp_a_o     = fp_a_q;
  assign fp_b_o     = fp_b_q;

endmodule

// File: rtl/fpadd_axil_regs.sv
// AXI4-Lite register front-end for the fpadd core: OPA/OPB/CTRL-STAT/RESULT, one outstanding
// write and one outstanding read; readies are registered so they are low throughout reset.
module fpadd_axil_regs
  import fpadd_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FP_TIMEOUT         = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [31:0]                       fp_a,
  output logic [31:0]                       fp_b,
  output logic                              fp_start,
  input  logic                              fp_done,
  input  logic [31:0]                       fp_result
);

  logic        aw_held_q, aw_held_d;
  logic [3:0]  awaddr_q, awaddr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        tmo_q, tmo_d;

  logic        aw_hs, w_hs, ar_hs, wr_en, start_req;
  logic        busy, done_set, ovr_set, tmo_set;
  logic [31:0] ctrl_rd;
  logic        unused_inputs;

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs = s00_axi_awvalid && awready_q;
  assign w_hs  = s00_axi_wvalid && wready_q;
  assign ar_hs = s00_axi_arvalid && arready_q;
  assign wr_en = aw_held_q && w_held_q;

  always_comb begin
    ctrl_rd           = '0;
    ctrl_rd[BUSY_BIT] = busy;
    ctrl_rd[DONE_BIT] = done_q;
    ctrl_rd[OVR_BIT]  = ovr_q;
    ctrl_rd[TMO_BIT]  = tmo_q;
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    start_req = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = {s00_axi_awaddr[3:2], 2'b00};
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s00_axi_wdata;
      wstrb_d  = s00_axi_wstrb;
    end

    if (wr_en) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (awaddr_q)
        ADDR_OPA: opa_d = apply_wstrb(opa_q, wdata_q, wstrb_q);
        ADDR_OPB: opb_d = apply_wstrb(opb_q, wdata_q, wstrb_q);
        ADDR_CTRL: begin
          if (wstrb_q[0]) begin
            start_req = wdata_q[START_BIT];
            if (wdata_q[DONE_BIT]) done_d = 1'b0;
            if (wdata_q[OVR_BIT])  ovr_d  = 1'b0;
            if (wdata_q[TMO_BIT])  tmo_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // Set pulses come after the W1C decode so a same-cycle set wins.
    if (done_set) begin
      done_d = 1'b1;
      res_d  = fp_result;
    end
    if (ovr_set) ovr_d = 1'b1;
    if (tmo_set) tmo_d = 1'b1;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      case ({s00_axi_araddr[3:2], 2'b00})
        ADDR_OPA:  rdata_d = opa_q;
        ADDR_OPB:  rdata_d = opb_q;
        ADDR_CTRL: rdata_d = ctrl_rd;
        default:   rdata_d = res_q;
      endcase
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
    end
  end

  fpadd_launch_ctrl #(
    .FP_TIMEOUT(FP_TIMEOUT)
  ) u_launch (
    .clk_i      (s00_axi_aclk),
    .rst_n_i    (s00_axi_aresetn),
    .start_req_i(start_req),
    .opa_i      (opa_q),
    .opb_i      (opb_q),
    .fp_done_i  (fp_done),
    .busy_o     (busy),
    .fp_start_o (fp_start),
    .fp_a_o     (fp_a),
    .fp_b_o     (fp_b),
    .done_set_o (done_set),
    .ovr_set_o  (ovr_set),
    .tmo_set_o  (tmo_set)
  );

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = AXI_RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = AXI_RESP_OKAY;

endmodule
